// File: rtl/cga_vram_arbiter.sv
// Arbitrates the CGA video RAM between the display fetch path and ISA CPU accesses.
// The CPU gets the RAM only inside sequencer windows; bus_rdy stretches the ISA cycle meanwhile.
module cga_vram_arbiter #(
    parameter int USE_BUS_WAIT  = 1,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        isa_op_enable,
    input  logic [18:0] disp_a,
    input  logic [14:0] bus_a,
    input  logic        bus_mem_cs,
    input  logic        bus_memr_l,
    input  logic        bus_memw_l,
    input  logic [7:0]  bus_d,
    input  logic [7:0]  ram_d,
    output logic [18:0] ram_a,
    output logic        ram_we_l,
    output logic [7:0]  ram_d_out,
    output logic [7:0]  bus_out_mem,
    output logic        bus_dir_mem,
    output logic        bus_rdy,
    output logic        cpu_grant
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(ACCESS_CYCLES - 1);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        rdy_q;
    logic        wr_q;
    logic [7:0]  out_q;
    logic [14:0] addr_q;
    logic [7:0]  data_q;
    logic [1:0]  memr_sync_q;
    logic [1:0]  memw_sync_q;
    logic        rd_req;
    logic        wr_req;
    logic        req;
    logic        win;

    // ISA strobes are asynchronous to clk; resetting to 1 keeps them inactive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memr_sync_q <= 2'b11;
            memw_sync_q <= 2'b11;
        end else begin
            memr_sync_q <= {memr_sync_q[0], bus_memr_l};
            memw_sync_q <= {memw_sync_q[0], bus_memw_l};
        end
    end

    assign rd_req = bus_mem_cs & ~memr_sync_q[1];
    assign wr_req = bus_mem_cs & ~memw_sync_q[1];
    assign req    = rd_req | wr_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            rdy_q   <= 1'b1;
            wr_q    <= 1'b0;
            out_q   <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        wr_q    <= wr_req;
                        rdy_q   <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (isa_op_enable) begin
                        cnt_q   <= 3'd0;
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // A closing window discards the partial access; the next window restarts the count.
                    if (!isa_op_enable) begin
                        state_q <= S_WAIT;
                    end else if (cnt_q == LAST_CNT) begin
                        if (!wr_q) out_q <= ram_d;
                        rdy_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_DONE: begin
                    if (!req) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && req) begin
            addr_q <= bus_a;
            data_q <= bus_d;
        end
    end

    // Gating with isa_op_enable releases the RAM in the very clock the window closes.
    assign win         = (state_q == S_ACCESS) & isa_op_enable;
    assign cpu_grant   = win;
    assign ram_a       = win ? {4'h0, addr_q} : disp_a;
    assign ram_we_l    = ~(win & wr_q);
    assign ram_d_out   = data_q;
    assign bus_out_mem = out_q;
    assign bus_dir_mem = bus_mem_cs & ~bus_memr_l;
    assign bus_rdy     = (USE_BUS_WAIT != 0) ? rdy_q : 1'b1;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed bench for cga_vram_arbiter: a wait-state instance and a no-wait instance
// share one stimulus stream and are both checked against hand-computed values.
module tb_cga_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        isa_op_enable;
    logic [18:0] disp_a;
    logic [14:0] bus_a;
    logic        bus_mem_cs;
    logic        bus_memr_l;
    logic        bus_memw_l;
    logic [7:0]  bus_d;
    logic [7:0]  ram_d;

    logic [18:0] ram_a, nw_ram_a;
    logic        ram_we_l, nw_ram_we_l;
    logic [7:0]  ram_d_out, nw_ram_d_out;
    logic [7:0]  bus_out_mem, nw_bus_out_mem;
    logic        bus_dir_mem, nw_bus_dir_mem;
    logic        bus_rdy, nw_bus_rdy;
    logic        cpu_grant, nw_cpu_grant;

    int n_chk = 0;
    int n_err = 0;

    int we_lo, nw_we_lo, rdy_lo, nw_rdy_lo, grant_n, nw_grant_n;
    int addr_err, data_err, disp_err, nw_addr_err;

    always #5 clk = ~clk;

    cga_vram_arbiter #(.USE_BUS_WAIT(1), .ACCESS_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .isa_op_enable(isa_op_enable), .disp_a(disp_a),
        .bus_a(bus_a), .bus_mem_cs(bus_mem_cs), .bus_memr_l(bus_memr_l),
        .bus_memw_l(bus_memw_l), .bus_d(bus_d), .ram_d(ram_d),
        .ram_a(ram_a), .ram_we_l(ram_we_l), .ram_d_out(ram_d_out),
        .bus_out_mem(bus_out_mem), .bus_dir_mem(bus_dir_mem),
        .bus_rdy(bus_rdy), .cpu_grant(cpu_grant)
    );

    cga_vram_arbiter #(.USE_BUS_WAIT(0), .ACCESS_CYCLES(2)) dut_nw (
        .clk(clk), .reset(reset), .isa_op_enable(isa_op_enable), .disp_a(disp_a),
        .bus_a(bus_a), .bus_mem_cs(bus_mem_cs), .bus_memr_l(bus_memr_l),
        .bus_memw_l(bus_memw_l), .bus_d(bus_d), .ram_d(ram_d),
        .ram_a(nw_ram_a), .ram_we_l(nw_ram_we_l), .ram_d_out(nw_ram_d_out),
        .bus_out_mem(nw_bus_out_mem), .bus_dir_mem(nw_bus_dir_mem),
        .bus_rdy(nw_bus_rdy), .cpu_grant(nw_cpu_grant)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        we_lo = 0; nw_we_lo = 0; rdy_lo = 0; nw_rdy_lo = 0; grant_n = 0; nw_grant_n = 0;
        addr_err = 0; data_err = 0; disp_err = 0; nw_addr_err = 0;
    endtask

    // Advance n clocks, sampling 3 time units after each rising edge.
    task automatic run_cycles(input int n, input logic [18:0] ea, input logic [7:0] ed);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #3;
            if (!ram_we_l) we_lo++;
            if (!nw_ram_we_l) nw_we_lo++;
            if (!bus_rdy) rdy_lo++;
            if (!nw_bus_rdy) nw_rdy_lo++;
            if (cpu_grant) begin
                grant_n++;
                if (ram_a !== ea) addr_err++;
                if (!ram_we_l && ram_d_out !== ed) data_err++;
            end else if (ram_a !== disp_a || !ram_we_l) begin
                disp_err++;
            end
            if (nw_cpu_grant) begin
                nw_grant_n++;
                if (nw_ram_a !== ea) nw_addr_err++;
            end else if (nw_ram_a !== disp_a) begin
                nw_addr_err++;
            end
        end
    endtask

    task automatic wait_we_low(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #3;
            if (!ram_we_l) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        reset = 1'b1; isa_op_enable = 1'b0; disp_a = 19'h12345; bus_a = 15'h0;
        bus_mem_cs = 1'b0; bus_memr_l = 1'b1; bus_memw_l = 1'b1; bus_d = 8'h00; ram_d = 8'h00;
        #1;
        check("rst_rdy", 32'(bus_rdy), 32'd1);
        check("rst_grant", 32'(cpu_grant), 32'd0);
        check("rst_we", 32'(ram_we_l), 32'd1);
        check("rst_out", 32'(bus_out_mem), 32'h00);
        check("rst_ram_a", 32'(ram_a), 32'h12345);
        check("rst_nw_rdy", 32'(nw_bus_rdy), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Write with the window open
        isa_op_enable = 1'b1; bus_mem_cs = 1'b1; bus_a = 15'h0123; bus_d = 8'hA5; bus_memw_l = 1'b0;
        clr_mon();
        run_cycles(10, 19'h00123, 8'hA5);
        check("wr_we_clocks", 32'(we_lo), 32'd2);
        check("wr_nw_we_clocks", 32'(nw_we_lo), 32'd2);
        check("wr_addr", 32'(addr_err), 32'd0);
        check("wr_data", 32'(data_err), 32'd0);
        check("wr_rdy_lo", 32'(rdy_lo), 32'd3);
        check("wr_nw_rdy_lo", 32'(nw_rdy_lo), 32'd0);
        check("wr_rdy_end", 32'(bus_rdy), 32'd1);
        check("wr_no_capture", 32'(bus_out_mem), 32'h00);
        bus_memw_l = 1'b1;
        run_cycles(4, 19'h00123, 8'hA5);

        // Read held off by a closed window for well over 10 clocks
        isa_op_enable = 1'b0; disp_a = 19'h5A5A5; bus_a = 15'h7FFF; ram_d = 8'h3C; bus_memr_l = 1'b0;
        #1;
        check("dir_rd", 32'(bus_dir_mem), 32'd1);
        clr_mon();
        run_cycles(14, 19'h07FFF, 8'h00);
        check("rd_rdy_lo_ge10", 32'(rdy_lo >= 10), 32'd1);
        check("rd_no_grant", 32'(grant_n), 32'd0);
        check("rd_disp_path", 32'(disp_err), 32'd0);
        check("rd_nw_rdy_lo", 32'(nw_rdy_lo), 32'd0);
        isa_op_enable = 1'b1;
        clr_mon();
        run_cycles(6, 19'h07FFF, 8'h00);
        check("rd_grant_clocks", 32'(grant_n), 32'd2);
        check("rd_no_we", 32'(we_lo), 32'd0);
        check("rd_addr", 32'(addr_err), 32'd0);
        check("rd_data", 32'(bus_out_mem), 32'h3C);
        check("rd_nw_data", 32'(nw_bus_out_mem), 32'h3C);
        check("rd_rdy_end", 32'(bus_rdy), 32'd1);
        bus_memr_l = 1'b1;
        #1;
        check("dir_idle", 32'(bus_dir_mem), 32'd0);
        run_cycles(4, 19'h07FFF, 8'h00);

        // Window drops in the second access clock
        ram_d = 8'h77; disp_a = 19'h2BCDE; bus_a = 15'h0456; bus_d = 8'h5A; bus_memw_l = 1'b0;
        wait_we_low("ab_first_seen");
        @(posedge clk);
        #1;
        isa_op_enable = 1'b0;
        #1;
        check("ab_we_same_clk", 32'(ram_we_l), 32'd1);
        check("ab_ram_a_same_clk", 32'(ram_a), 32'h2BCDE);
        check("ab_grant_same_clk", 32'(cpu_grant), 32'd0);
        check("ab_nw_we_same_clk", 32'(nw_ram_we_l), 32'd1);
        clr_mon();
        run_cycles(5, 19'h00456, 8'h5A);
        check("ab_closed_no_we", 32'(we_lo), 32'd0);
        check("ab_closed_rdy_lo", 32'(rdy_lo), 32'd5);
        isa_op_enable = 1'b1;
        clr_mon();
        run_cycles(6, 19'h00456, 8'h5A);
        check("ab_restart_we", 32'(we_lo), 32'd2);
        check("ab_restart_nw_we", 32'(nw_we_lo), 32'd2);
        check("ab_restart_addr", 32'(addr_err), 32'd0);
        check("ab_restart_data", 32'(data_err), 32'd0);
        check("ab_out_hold", 32'(bus_out_mem), 32'h3C);
        bus_memw_l = 1'b1;
        run_cycles(4, 19'h00456, 8'h5A);

        // Both strobes held low for 30 clocks: a single write
        bus_a = 15'h0ABC; bus_d = 8'hC3; bus_memw_l = 1'b0; bus_memr_l = 1'b0;
        clr_mon();
        run_cycles(30, 19'h00ABC, 8'hC3);
        check("hold_we_clocks", 32'(we_lo), 32'd2);
        check("hold_nw_we_clocks", 32'(nw_we_lo), 32'd2);
        check("hold_addr", 32'(addr_err), 32'd0);
        check("hold_data", 32'(data_err), 32'd0);
        check("hold_is_write", 32'(bus_out_mem), 32'h3C);
        check("hold_rdy", 32'(bus_rdy), 32'd1);
        bus_memw_l = 1'b1; bus_memr_l = 1'b1;
        run_cycles(4, 19'h00ABC, 8'hC3);
        bus_d = 8'h11; bus_memw_l = 1'b0;
        clr_mon();
        run_cycles(10, 19'h00ABC, 8'h11);
        check("rearm_we_clocks", 32'(we_lo), 32'd2);
        check("rearm_data", 32'(data_err), 32'd0);
        bus_memw_l = 1'b1;
        run_cycles(4, 19'h00ABC, 8'h11);

        // Strobe released while waiting for a window
        isa_op_enable = 1'b0; bus_a = 15'h0321; bus_d = 8'h99; bus_memw_l = 1'b0;
        clr_mon();
        run_cycles(6, 19'h00321, 8'h99);
        bus_memw_l = 1'b1;
        run_cycles(4, 19'h00321, 8'h99);
        isa_op_enable = 1'b1;
        run_cycles(6, 19'h00321, 8'h99);
        check("rel_we_clocks", 32'(we_lo), 32'd2);
        check("rel_addr", 32'(addr_err), 32'd0);
        check("rel_data", 32'(data_err), 32'd0);
        check("rel_disp_path", 32'(disp_err), 32'd0);
        check("rel_rdy_end", 32'(bus_rdy), 32'd1);
        check("rel_nw_addr", 32'(nw_addr_err), 32'd0);

        // Reset asserted in the middle of an access
        bus_a = 15'h0111; bus_d = 8'hEE; bus_memw_l = 1'b0;
        wait_we_low("rst_mid_seen");
        reset = 1'b1;
        #1;
        check("rstm_we", 32'(ram_we_l), 32'd1);
        check("rstm_rdy", 32'(bus_rdy), 32'd1);
        check("rstm_grant", 32'(cpu_grant), 32'd0);
        check("rstm_out", 32'(bus_out_mem), 32'h00);
        check("rstm_nw_we", 32'(nw_ram_we_l), 32'd1);
        bus_memw_l = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        clr_mon();
        run_cycles(4, 19'h00111, 8'hEE);
        check("rstm_discarded", 32'(we_lo), 32'd0);
        check("rstm_rdy_after", 32'(rdy_lo), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cga_vram_arbiter.md
CGA_VRAM_ARBITER -- requirements
Module: cga_vram_arbiter

Interface
REQ-001 SHALL have parameter USE_BUS_WAIT, default 1: 1 means insert ISA wait states; 0 means bus_rdy is tied high and CPU accesses are still serialized.
REQ-002 SHALL have parameter ACCESS_CYCLES, default 2: clocks of RAM ownership per CPU access, legal range 1-7.
REQ-003 SHALL have port clk, input, 1: single system clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port isa_op_enable, input, 1: sequencer CPU window; RAM is free for CPU while high.
REQ-006 SHALL have port disp_a, input, 19: display fetch address.
REQ-007 SHALL have port bus_a, input, 15: CPU offset within the framebuffer.
REQ-008 SHALL have port bus_mem_cs, input, 1: CPU address decodes to the framebuffer.
REQ-009 SHALL have ports bus_memr_l and bus_memw_l, inputs, 1 each: asynchronous ISA strobes, active-low.
REQ-010 SHALL have port bus_d, input, 8: CPU write data.
REQ-011 SHALL have port ram_d, input, 8: RAM read data, valid in the clock after an address is presented.
REQ-012 SHALL have port ram_a, output, 19: RAM address.
REQ-013 SHALL have port ram_we_l, output, 1: RAM write strobe, active-low.
REQ-014 SHALL have port ram_d_out, output, 8: RAM write data.
REQ-015 SHALL have port bus_out_mem, output, 8: latched CPU read data.
REQ-016 SHALL have port bus_dir_mem, output, 1: high while bus_mem_cs & ~bus_memr_l, combinational.
REQ-017 SHALL have port bus_rdy, output, 1: ISA ready; low inserts wait states.
REQ-018 SHALL have port cpu_grant, output, 1: high while the CPU owns the RAM.

Function
REQ-019 SHALL synchronize bus_memr_l and bus_memw_l through 2 flops each; rd_req = bus_mem_cs & ~memr_sync; wr_req = bus_mem_cs & ~memw_sync; req = rd_req | wr_req.
REQ-020 SHALL implement states IDLE, WAIT, ACCESS, DONE, encoded as 2 bits.
REQ-021 IDLE: on req, SHALL latch bus_a, bus_d and the write flag (wr_req) and go to WAIT; bus_rdy SHALL be low from the next clock.
REQ-022 WAIT: SHALL go to ACCESS in the first clock in which isa_op_enable=1, and SHALL clear the access counter.
REQ-023 ACCESS: cpu_grant=1, ram_a={4'h0, latched bus_a}, ram_d_out=latched data, and ram_we_l=~write_flag; the counter SHALL increment each clock.
REQ-024 ACCESS completion: when the counter reaches ACCESS_CYCLES-1, SHALL capture ram_d into bus_out_mem (reads only) and go to DONE.
REQ-025 ACCESS abort: if isa_op_enable falls before completion, SHALL return to WAIT with ram_we_l=1 the same clock and restart the full count at the next window; data is neither committed nor captured.
REQ-026 DONE: bus_rdy=1; SHALL stay until req=0 for one clock, then go to IDLE. This gives one access per strobe assertion.
REQ-027 Outside ACCESS: ram_a=disp_a, ram_we_l=1, cpu_grant=0; the display path SHALL never be blocked outside CPU windows.
REQ-028 Both strobes low simultaneously in IDLE SHALL be treated as a write.
REQ-029 Strobe deassertion during WAIT or ACCESS SHALL NOT cancel the access; it completes, then DONE exits immediately.
REQ-030 With USE_BUS_WAIT=0: bus_rdy=1 constantly; the state machine is unchanged.
REQ-031 bus_out_mem SHALL hold its value until the next completed read.

Reset
REQ-032 While reset is asserted: state=IDLE, counter=0, bus_rdy=1, cpu_grant=0, ram_we_l=1, bus_out_mem=8'h00, and the sync flops hold 1 (inactive).
REQ-033 Reset asserted mid-ACCESS SHALL force ram_we_l=1 immediately (asynchronously); the pending access is discarded.

Verification
REQ-034 Write, window open: isa_op_enable=1, bus_a=15'h0123, bus_d=8'hA5, memw low → ram_a=19'h00123 and ram_we_l low for exactly 2 clocks, then bus_rdy high.
REQ-035 Read, window closed 10 clocks: rd to 15'h7FFF, ram_d=8'h3C → bus_rdy low for at least 10 clocks, ram_a=disp_a throughout the wait, then bus_out_mem=8'h3C.
REQ-036 Abort: window drops after 1 of 2 access clocks → ram_we_l=1 and ram_a=disp_a the same clock; the access restarts and takes a full 2 clocks at the next window.
REQ-037 Held strobe: memw held low for 30 clocks → exactly one write (ram_we_l low 2 clocks total); IDLE is reached only after strobe release.
REQ-038 Reset mid-ACCESS → ram_we_l=1, bus_rdy=1, state IDLE with no clock edge required.
REQ-039 USE_BUS_WAIT=0 → bus_rdy=1 in all of the above scenarios; RAM traffic is identical.
